// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: voice count, sample format and the mix sequencer states.
package synth_pkg;
    localparam int NUM_VOICES = 8;
    localparam int SAMPLE_W   = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE, OUT} mixseq_state_t;
endpackage

// File: rtl/mix_saturate.sv
// Arithmetic right shift of a wide accumulator followed by a clamp to a signed DW-bit sample.
module mix_saturate #(
    parameter int DW    = 16,
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [1:0]       shift,
    output logic signed [DW-1:0]    sat
);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> shift;

    always_comb begin
        if (shifted > MAXV)      sat = MAXV[DW-1:0];
        else if (shifted < MINV) sat = MINV[DW-1:0];
        else                     sat = shifted[DW-1:0];
    end
endmodule

// File: rtl/voice_mix_sequencer.sv
// Walks the one-hot voice mux once per sample tick, sums the enabled voices, then
// scales/saturates the sum and hands it downstream over valid/ready.
module voice_mix_sequencer import synth_pkg::*; #(
    parameter int DW    = SAMPLE_W,
    parameter int ACC_W = DW + $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic [1:0]            gain_shift,
    output logic [NUM_VOICES-1:0] sel_oneHot,
    input  logic signed [DW-1:0]  mux_data,
    output logic signed [DW-1:0]  mix_out,
    output logic                  mix_valid,
    input  logic                  mix_ready,
    output logic                  busy,
    output logic                  overrun
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES-1);

    mixseq_state_t           state, state_d;
    logic [IW-1:0]           idx, idx_n;
    logic [NUM_VOICES-1:0]   en_q, sel_first, sel_next;
    logic [1:0]              sh_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    sat_out;
    logic                    start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // A tick is taken in IDLE, or in OUT on the very cycle the result is accepted.
    always_comb begin
        state_d = state;
        start   = 1'b0;
        overrun = 1'b0;
        case (state)
            IDLE: if (sample_tick) begin
                start   = 1'b1;
                state_d = SCAN;
            end
            SCAN: begin
                overrun = sample_tick;
                if (idx == LAST) state_d = DONE;
            end
            DONE: begin
                overrun = sample_tick;
                state_d = OUT;
            end
            OUT: if (mix_ready) begin
                start   = sample_tick;
                state_d = sample_tick ? SCAN : IDLE;
            end else begin
                overrun = sample_tick;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state == SCAN) || (state == DONE);
    assign idx_n = idx + 1'b1;

    // Select is registered, so it is computed one cycle ahead of the scan slot it drives.
    always_comb begin
        sel_first = {{(NUM_VOICES-1){1'b0}}, voice_en[0]};
        sel_next  = '0;
        if (idx != LAST && en_q[idx_n]) sel_next = {{(NUM_VOICES-1){1'b0}}, 1'b1} << idx_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= '0;
            sh_q       <= '0;
            acc        <= '0;
            idx        <= '0;
            sel_oneHot <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (|sel_oneHot) acc <= acc + {{(ACC_W-DW){mux_data[DW-1]}}, mux_data};
                    idx        <= idx_n;
                    sel_oneHot <= sel_next;
                end
                DONE: begin
                    mix_out   <= sat_out;
                    mix_valid <= 1'b1;
                end
                OUT: if (mix_ready) mix_valid <= 1'b0;
                default: ;
            endcase
            if (start) begin
                en_q       <= voice_en;
                sh_q       <= gain_shift;
                acc        <= '0;
                idx        <= '0;
                sel_oneHot <= sel_first;
            end
        end
    end

    mix_saturate #(.DW(DW), .ACC_W(ACC_W)) u_sat (
        .acc   (acc),
        .shift (sh_q),
        .sat   (sat_out)
    );
endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: behavioural one-hot mux as datapath, queued expectations
// for select sequence and mixed samples, checked by an independent negedge monitor.
module tb_voice_mix_sequencer;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic [7:0]         voice_en = '0;
    logic [1:0]         gain_shift = '0;
    logic [7:0]         sel_oneHot;
    logic signed [15:0] mux_data;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               mix_ready = 1'b1;
    logic               busy;
    logic               overrun;

    logic signed [15:0] voices [8];

    int total = 0, passed = 0, hs_count = 0, cyc = 0, t0 = 0;
    bit exp_ovr = 1'b0, prev_valid = 1'b0;
    int sel_q[$];
    int mix_q[$];

    voice_mix_sequencer dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .voice_en(voice_en),
        .gain_shift(gain_shift), .sel_oneHot(sel_oneHot), .mux_data(mux_data),
        .mix_out(mix_out), .mix_valid(mix_valid), .mix_ready(mix_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // One-hot mux: no select falls back to voice 0.
    always_comb begin
        mux_data = voices[0];
        for (int i = 0; i < 8; i++) if (sel_oneHot[i]) mux_data = voices[i];
    end

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            chk("overrun", int'(overrun), int'(exp_ovr));
            if (busy) begin
                if (sel_q.size() > 0) chk("sel", int'(sel_oneHot), sel_q.pop_front());
                else chk("sel_extra_busy", int'(busy), 0);
            end else begin
                chk("sel_idle", int'(sel_oneHot), 0);
            end
            if (mix_valid) begin
                if (!prev_valid) chk("latency", cyc - t0, 10);
                if (mix_q.size() > 0) begin
                    chk("mix_out", int'(mix_out), mix_q[0]);
                    if (mix_ready) begin
                        void'(mix_q.pop_front());
                        hs_count++;
                    end
                end else begin
                    chk("mix_extra", int'(mix_valid), 0);
                end
            end
            if (sample_tick && !exp_ovr) t0 = cyc;
            prev_valid = mix_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input logic [7:0] en, input logic [1:0] sh, input bit ovr);
        step(1);
        sample_tick = 1'b1; voice_en = en; gain_shift = sh; exp_ovr = ovr;
        step(1);
        sample_tick = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic push_pass(input logic [7:0] en, input int val);
        for (int i = 0; i < 8; i++) sel_q.push_back(en[i] ? (1 << i) : 0);
        sel_q.push_back(0);
        mix_q.push_back(val);
    endtask

    task automatic set_voices(input int base, input int inc);
        for (int i = 0; i < 8; i++) voices[i] = 16'(base + i * inc);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!(sel_q.size() == 0 && mix_q.size() == 0 && !busy && !mix_valid) && n < 200);
        if (n >= 200)
            chk("drain_timeout", sel_q.size() + mix_q.size() + int'(busy) + int'(mix_valid), 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_sel"},   int'(sel_oneHot), 0);
        chk({tag, "_out"},   int'(mix_out), 0);
        chk({tag, "_valid"}, int'(mix_valid), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_ovr"},   int'(overrun), 0);
    endtask

    initial begin
        set_voices(0, 0);
        step(3);
        check_quiet("reset");
        reset_n = 1'b1;
        step(2);

        // Full mask, unity gain.
        set_voices(100, 100);
        push_pass(8'hFF, 3600);
        tick(8'hFF, 2'd0, 1'b0);
        wait_done();

        // Sparse mask with halving; masked voices must not leak in.
        set_voices(555, 0);
        voices[0] = 16'sd1000;
        voices[2] = -16'sd3000;
        push_pass(8'h05, -1000);
        tick(8'h05, 2'd1, 1'b0);
        wait_done();

        // Saturation boundaries.
        set_voices(32767, 0);
        push_pass(8'hFF, 32767);  tick(8'hFF, 2'd0, 1'b0); wait_done();
        push_pass(8'hFF, 32767);  tick(8'hFF, 2'd3, 1'b0); wait_done();
        set_voices(-32768, 0);
        push_pass(8'hFF, -32768); tick(8'hFF, 2'd0, 1'b0); wait_done();
        push_pass(8'hFF, -32768); tick(8'hFF, 2'd3, 1'b0); wait_done();
        set_voices(30000, 0);
        push_pass(8'hFF, 32767);  tick(8'hFF, 2'd2, 1'b0); wait_done();

        // Empty mask; mid-pass mask change must be ignored.
        set_voices(100, 100);
        push_pass(8'h00, 0);
        tick(8'h00, 2'd0, 1'b0);
        step(3);
        voice_en = 8'hFF;
        wait_done();

        // Downstream stall with dropped ticks, then a tick on the handshake cycle.
        mix_ready = 1'b0;
        push_pass(8'hFF, 1800);
        tick(8'hFF, 2'd1, 1'b0);
        step(1);
        tick(8'h00, 2'd3, 1'b1);
        step(10);
        tick(8'h00, 2'd3, 1'b1);
        step(4);
        mix_ready = 1'b1;
        push_pass(8'h0F, 1000);
        sample_tick = 1'b1; voice_en = 8'h0F; gain_shift = 2'd0; exp_ovr = 1'b0;
        step(1);
        sample_tick = 1'b0;
        wait_done();

        // Reset in the middle of a scan, then a fresh pass.
        push_pass(8'hFF, 3600);
        tick(8'hFF, 2'd0, 1'b0);
        step(4);
        reset_n = 1'b0;
        sel_q.delete();
        mix_q.delete();
        #1;
        check_quiet("midreset");
        step(2);
        reset_n = 1'b1;
        step(1);
        push_pass(8'hAA, 2000);
        tick(8'hAA, 2'd0, 1'b0);
        wait_done();

        chk("handshakes", hs_count, 11);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
